// File: rtl/clk_div_cfg_ctrl_if.sv
// Configuration / control / status bundle for clk_div_cfg_ctrl.
// The master side drives run control and divisor requests; the slave side
// (the divider) returns the handshake, error pulse, divided clock and status.
interface clk_div_cfg_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clock_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] cur_div;

    modport master (
        output enable, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, clock_out, tick, busy, cur_div
    );

    modport slave (
        input  enable, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, clock_out, tick, busy, cur_div
    );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Runtime-reconfigurable clock divider controller.
// Divisor updates arrive over a valid/ready port and are only applied at a
// period boundary, so clock_out never glitches mid-period. A one-cycle tick
// marks the last cycle of every divided period.
// Optional feature: define CLK_DIV_CFG_CTRL_PERIOD_CNT_EN to add a 16-bit
// period counter output (period_cnt).
module clk_div_cfg_ctrl #(
    parameter int CNT_W       = 4,
    parameter int DEFAULT_DIV = 5,
    parameter int MIN_DIV     = 2
) (
    input  logic              clock_in,
    input  logic              rst,
    clk_div_cfg_ctrl_if.slave bus
`ifdef CLK_DIV_CFG_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]       period_cnt
`endif
);

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_div;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] half_div;
    logic             clock_out;
    logic             tick;
    logic             cfg_err;
    logic             cfg_ready;
    logic             running;
    logic             accept;
    logic             legal;
    logic             boundary;

    // Handshake and period-boundary decode, all derived from current state
    assign running   = (state == ST_RUN) || (state == ST_PEND);
    assign cfg_ready = (state != ST_PEND);
    assign accept    = bus.cfg_valid && cfg_ready;
    assign legal     = (bus.cfg_div >= CNT_W'(MIN_DIV));
    assign half_div  = cur_div >> 1;
    // cur_div is never below MIN_DIV, so cur_div-1 cannot underflow
    assign boundary  = running && (cnt == cur_div - CNT_W'(1));

    assign bus.cfg_ready = cfg_ready;
    assign bus.cfg_err   = cfg_err;
    assign bus.clock_out = clock_out;
    assign bus.tick      = tick;
    assign bus.busy      = running;
    assign bus.cur_div   = cur_div;

    // Control FSM, period counter and divisor registers
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state    <= ST_STOP;
            cnt      <= '0;
            cur_div  <= CNT_W'(DEFAULT_DIV);
            pend_div <= '0;
        end else begin
            case (state)
                ST_STOP: begin
                    cnt <= '0;
                    // A legal request while stopped takes effect directly,
                    // so an enable in the same cycle runs with the new divisor
                    if (accept && legal) cur_div <= bus.cfg_div;
                    if (bus.enable)      state   <= ST_RUN;
                end
                ST_RUN: begin
                    cnt <= boundary ? '0 : cnt + CNT_W'(1);
                    // A request accepted even on a boundary waits for the
                    // next boundary; the current one completes with cur_div
                    if (accept && legal) begin
                        pend_div <= bus.cfg_div;
                        state    <= ST_PEND;
                    end else if (boundary && !bus.enable) begin
                        state <= ST_STOP;
                    end
                end
                ST_PEND: begin
                    cnt <= boundary ? '0 : cnt + CNT_W'(1);
                    if (boundary) begin
                        cur_div <= pend_div;
                        state   <= bus.enable ? ST_RUN : ST_STOP;
                    end
                end
                // NOTE: the unused encoding recovers to STOP; every branch
                // assigns registers only, so no latch can be inferred.
                default: begin
                    state <= ST_STOP;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Registered outputs: one clock behind cnt, forced low while stopped
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            clock_out <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            clock_out <= running && (cnt < half_div);
            tick      <= boundary;
            cfg_err   <= accept && !legal;
        end
    end

`ifdef CLK_DIV_CFG_CTRL_PERIOD_CNT_EN
    // Completed-period counter, restarted whenever the divider starts running
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if ((state == ST_STOP) && bus.enable) begin
            period_cnt <= '0;
        end else if (boundary) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`else
    // Period counter feature not built
`endif

endmodule
